// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin add/subtract unit with a one-entry result register
// Optional signed-overflow output res_ovf is enabled by defining ADDSUB_ARB_OVF_EN.
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_s,
  output logic             res_cout,
`ifdef ADDSUB_ARB_OVF_EN
  output logic             res_ovf,
`endif
  output logic             res_id
);

  typedef enum logic {IDLE, RESULT} state_t;

  state_t           state;
  logic             last_id;
  logic             grant;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_mode;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;

  // On a tie the requester that did not produce the last result wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_id;
    else                          grant = req1_valid;
  end

  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;

  assign sel_a    = grant ? req1_a    : req0_a;
  assign sel_b    = grant ? req1_b    : req0_b;
  assign sel_mode = grant ? req1_mode : req0_mode;
  assign b_x      = sel_b ^ {WIDTH{sel_mode}};
  assign sum      = {1'b0, sel_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sel_mode};

`ifdef ADDSUB_ARB_OVF_EN
  logic ovf;
  // Same-sign operands producing an opposite-sign result == carry-in XOR carry-out of the MSB.
  assign ovf = (sel_a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != sel_a[WIDTH-1]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_s     <= '0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
      last_id   <= 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
      res_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            state     <= RESULT;
            res_valid <= 1'b1;
            res_s     <= sum[WIDTH-1:0];
            res_cout  <= sum[WIDTH];
            res_id    <= grant;
`ifdef ADDSUB_ARB_OVF_EN
            res_ovf   <= ovf;
`endif
          end
        end
        RESULT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            last_id   <= res_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk edge.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1, requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1, block accepts that requester's operation this cycle.
REQ-006 SHALL have ports req0_a, req0_b / req1_a, req1_b, input, WIDTH, operands A and B.
REQ-007 SHALL have ports req0_mode / req1_mode, input, 1, 0 = A+B, 1 = A-B (two's complement: A + ~B + 1).
REQ-008 SHALL have port res_valid, output, 1, result registers hold a valid result.
REQ-009 SHALL have port res_ready, input, 1, consumer takes the result this cycle.
REQ-010 SHALL have ports res_s, output, WIDTH, sum/difference; res_cout, output, 1, carry out of MSB.
REQ-011 SHALL have port res_id, output, 1, index of the requester that produced the result.

Function
REQ-012 SHALL use a two-state FSM: IDLE (accepting) and RESULT (result held).
REQ-013 SHALL drive reqN_ready = (state == IDLE) && (grant == N), combinationally from the valids and the priority pointer.
REQ-014 SHALL grant the only valid requester; if both are valid, it SHALL grant the requester whose index differs from last_id (round-robin).
REQ-015 SHALL treat a handshake as reqN_valid && reqN_ready; an accepted operation SHALL move IDLE -> RESULT on the next edge.
REQ-016 SHALL register res_s = (A + (B ^ {WIDTH{mode}}) + mode) mod 2^WIDTH, res_cout = bit WIDTH of the same sum, and res_id = N on accept.
REQ-017 SHALL give a latency of 1 cycle: res_valid is high in the cycle after the handshake.
REQ-018 SHALL make the subtraction carry res_cout = 1 exactly when A >= B (unsigned), i.e. no borrow.
REQ-019 SHALL, in RESULT, hold res_valid, res_s, res_cout and res_id stable while res_ready = 0; both reqN_ready SHALL be 0.
REQ-020 SHALL, on res_valid && res_ready, go RESULT -> IDLE and update last_id = res_id; the next accept can occur one cycle later (max throughput 1 op / 2 cycles).
REQ-021 SHALL ignore a requester that drops valid before being granted (no pending state kept); operand inputs are sampled only at the handshake.
REQ-022 SHALL clear res_valid on the next edge after the result handshake; res_s, res_cout and res_id retain their last values.

Reset
REQ-023 SHALL, with rst_n = 0 at an edge, set state = IDLE, res_valid = 0, res_s = 0, res_cout = 0, res_id = 0, last_id = 1 (req0 wins the first tie).
REQ-024 SHALL hold req0_ready and req1_ready at 0 during any cycle in which rst_n = 0.
REQ-025 SHALL discard a held result on reset in RESULT; it is not presented again after reset.

Configuration
REQ-026 SHALL, when macro ADDSUB_ARB_OVF_EN is defined, add port res_ovf, output, 1, registered with the result as carry-into-MSB XOR carry-out-of-MSB (signed overflow), reset to 0.
REQ-027 SHALL, when ADDSUB_ARB_OVF_EN is undefined, have no res_ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-028 SHALL check: after reset, req0 only, A=0101 B=0011 mode=0, res_ready=1 -> next cycle res_valid=1, res_s=1000, res_cout=0, res_id=0.
REQ-029 SHALL check: req1 only, A=0110 B=0001 mode=1 -> res_s=0101, res_cout=1, res_id=1; then A=0011 B=0101 mode=1 -> res_s=1110, res_cout=0.
REQ-030 SHALL check: both valid continuously after reset -> grant order req0, req1, req0, req1; each ready pulse lasts one cycle; no two ready signals high together.
REQ-031 SHALL check: result 1000+0010 held with res_ready=0 for 5 cycles -> res_s=1010, res_valid stable, both ready=0; res_ready=1 -> IDLE next cycle.
REQ-032 SHALL check: rst_n=0 while in RESULT -> next edge res_valid=0, res_s=0, state IDLE; first tie after release goes to req0.
REQ-033 SHALL check, with ADDSUB_ARB_OVF_EN: 0111+0001 -> res_s=1000, res_ovf=1; 0111-0100 -> res_s=0011, res_ovf=0.
